dataflow_rr_merge: RTL and testbench

// - Round-robin N-to-1 merge for valid/ready sample streams; the counterpart of the fan-out fork.
// - Shares one downstream consumer (meter/peak-detect datapath) among CHANNELS producers, e.g. L/R audio.
// - One-entry registered output stage; each output word is tagged with its source channel index.
// - Full throughput: one transfer per clock while the consumer is ready.

---
 rtl/dataflow_rr_merge_pkg.sv | 10 +
 rtl/rr_priority_select.sv | 40 ++++
 rtl/dataflow_rr_merge.sv | 90 +++++++++
 tb/tb_dataflow_rr_merge.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dataflow_rr_merge_pkg.sv
// Shared helpers for the round-robin merge: modular pointer arithmetic over a
// channel count that need not be a power of two.
package dataflow_rr_merge_pkg;

    // Advance a channel index by one, wrapping at n.
    function automatic int unsigned wrap_inc(input int unsigned k, input int unsigned n);
        return (k == n - 32'd1) ? 32'd0 : k + 32'd1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational rotating-priority selector: returns the first asserted request
// at or after ptr, wrapping modulo CHANNELS.
module rr_priority_select
    import dataflow_rr_merge_pkg::*;
#(
    parameter int unsigned CHANNELS = 2
) (
    input  logic [CHANNELS-1:0]         req,
    input  logic [$clog2(CHANNELS)-1:0] ptr,
    output logic [$clog2(CHANNELS)-1:0] gnt_idx,
    output logic                        gnt_any
);

    localparam int unsigned CH_BITS = $clog2(CHANNELS);

    int unsigned k;
    logic        hit;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        k       = 32'(ptr);
        hit     = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            // Compare-based lookup keeps the index in range for non-power-of-2 counts.
            hit = 1'b0;
            for (int unsigned j = 0; j < CHANNELS; j++) begin
                if (j == k) begin
                    hit = req[j];
                end
            end
            if (!gnt_any && hit) begin
                gnt_any = 1'b1;
                gnt_idx = CH_BITS'(k);
            end
            k = wrap_inc(k, CHANNELS);
        end
    end

endmodule

// File: rtl/dataflow_rr_merge.sv
// Round-robin N-to-1 valid/ready merge with a one-entry registered output stage;
// each output word carries the index of the channel it came from.
module dataflow_rr_merge
    import dataflow_rr_merge_pkg::*;
#(
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [CHANNELS-1:0]         i_valid,
    output logic [CHANNELS-1:0]         i_ready,
    input  logic [CHANNELS*WIDTH-1:0]   i_data,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic [WIDTH-1:0]            o_data,
    output logic [$clog2(CHANNELS)-1:0] o_channel
);

    localparam int unsigned CH_BITS = $clog2(CHANNELS);

    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CH_BITS-1:0] chan_q, chan_d;
    logic [CH_BITS-1:0] rr_ptr_q, rr_ptr_d;

    logic [CH_BITS-1:0] gnt_idx;
    logic               gnt_any;
    logic               load_en;
    logic               in_xfer;
    logic [WIDTH-1:0]   sel_data;

    rr_priority_select #(
        .CHANNELS (CHANNELS)
    ) u_select (
        .req     (i_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Reset gates load_en so no producer sees ready while the block is held in reset.
    assign load_en = reset_n && (!valid_q || o_ready);
    assign in_xfer = load_en && gnt_any;

    always_comb begin
        i_ready  = '0;
        sel_data = '0;
        for (int unsigned j = 0; j < CHANNELS; j++) begin
            if (gnt_idx == CH_BITS'(j)) begin
                i_ready[j] = in_xfer;
                sel_data   = i_data[j*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        chan_d   = chan_q;
        rr_ptr_d = rr_ptr_q;
        if (in_xfer) begin
            valid_d  = 1'b1;
            data_d   = sel_data;
            chan_d   = gnt_idx;
            rr_ptr_d = CH_BITS'(wrap_inc(32'(gnt_idx), CHANNELS));
        end else if (valid_q && o_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            chan_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            chan_q   <= chan_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_channel = chan_q;

endmodule

// File: tb/tb_dataflow_rr_merge.sv
// Scoreboarded bench for dataflow_rr_merge: a 2-channel and a 3-channel instance
// driven with directed vectors; monitors pop expected words on each output transfer.
module tb_dataflow_rr_merge;

    localparam int unsigned W = 24;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // 2-channel instance
    logic [1:0]     i_valid2, i_ready2;
    logic [2*W-1:0] i_data2;
    logic           o_valid2, o_ready2;
    logic [W-1:0]   o_data2;
    logic           o_channel2;

    // 3-channel instance
    logic [2:0]     i_valid3, i_ready3;
    logic [3*W-1:0] i_data3;
    logic           o_valid3, o_ready3;
    logic [W-1:0]   o_data3;
    logic [1:0]     o_channel3;

    dataflow_rr_merge #(.WIDTH(W), .CHANNELS(2)) dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_valid   (i_valid2),
        .i_ready   (i_ready2),
        .i_data    (i_data2),
        .o_valid   (o_valid2),
        .o_ready   (o_ready2),
        .o_data    (o_data2),
        .o_channel (o_channel2)
    );

    dataflow_rr_merge #(.WIDTH(W), .CHANNELS(3)) dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_valid   (i_valid3),
        .i_ready   (i_ready3),
        .i_data    (i_data3),
        .o_valid   (o_valid3),
        .o_ready   (o_ready3),
        .o_data    (o_data3),
        .o_channel (o_channel3)
    );

    int checks = 0;
    int passes = 0;

    logic [31:0] q2[$];
    logic [31:0] q3[$];
    int unsigned seq3[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [W-1:0] word3(input int unsigned k, input int unsigned s);
        return W'(((k + 1) << 20) | s);
    endfunction

    task automatic update_data3();
        for (int unsigned k = 0; k < 3; k++) i_data3[k*W +: W] = word3(k, seq3[k]);
    endtask

    // Output monitors: sample on the falling edge, away from the transfer edge.
    always @(negedge clk) begin
        if (reset_n && o_valid2 && o_ready2) begin
            if (q2.size() == 0) begin
                checks++;
                $display("FAIL out2_extra: got ch %0d data %h, expected no word",
                         o_channel2, o_data2);
            end else begin
                check("out2_word", {7'd0, o_channel2, o_data2}, q2.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && o_valid3 && o_ready3) begin
            if (q3.size() == 0) begin
                checks++;
                $display("FAIL out3_extra: got ch %0d data %h, expected no word",
                         o_channel3, o_data3);
            end else begin
                check("out3_word", {6'd0, o_channel3, o_data3}, q3.pop_front());
            end
        end
    end

    initial begin
        logic [2:0]  acc;
        int unsigned n;
        int unsigned k;

        reset_n  = 1'b0;
        i_valid2 = '0; i_data2 = '0; o_ready2 = 1'b0;
        i_valid3 = '0; i_data3 = '0; o_ready3 = 1'b0;
        for (int i = 0; i < 3; i++) seq3[i] = 0;
        #1;
        check("reset_o_valid2", {31'd0, o_valid2}, 32'd0);
        check("reset_o_data2", {8'd0, o_data2}, 32'd0);
        check("reset_o_channel3", {30'd0, o_channel3}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Full-throughput alternation on two channels.
        i_data2  = {24'h000222, 24'h000111};
        o_ready2 = 1'b1;
        i_valid2 = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr2_i_ready", {30'd0, i_ready2}, (i % 2 == 0) ? 32'd1 : 32'd2);
            q2.push_back((i % 2 == 0) ? 32'h00_000111 : 32'h01_000222);
            @(posedge clk); #1;
            check("rr2_no_bubble", {31'd0, o_valid2}, 32'd1);
            check("rr2_channel", {31'd0, o_channel2}, 32'(i % 2));
        end
        i_valid2 = 2'b00;
        #1;
        check("idle2_i_ready", {30'd0, i_ready2}, 32'd0);
        @(posedge clk); #1;
        check("idle2_o_valid_fall", {31'd0, o_valid2}, 32'd0);
        check("idle2_data_hold", {8'd0, o_data2}, 32'h000222);
        @(posedge clk); #1;

        // Backpressure: word held, no grants, pointer frozen.
        o_ready2 = 1'b0;
        i_valid2 = 2'b11;
        #1;
        check("bp2_first_grant", {30'd0, i_ready2}, 32'd1);
        q2.push_back(32'h00_000111);
        @(posedge clk); #1;
        check("bp2_loaded", {31'd0, o_valid2}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp2_i_ready", {30'd0, i_ready2}, 32'd0);
            check("bp2_data", {8'd0, o_data2}, 32'h000111);
            check("bp2_channel", {31'd0, o_channel2}, 32'd0);
            @(posedge clk); #1;
        end
        o_ready2 = 1'b1;
        #1;
        check("bp2_release_grant", {30'd0, i_ready2}, 32'd2);
        q2.push_back(32'h01_000222);
        @(posedge clk); #1;
        check("bp2_swap_valid", {31'd0, o_valid2}, 32'd1);
        check("bp2_swap_channel", {31'd0, o_channel2}, 32'd1);
        check("bp2_swap_data", {8'd0, o_data2}, 32'h000222);
        i_valid2 = 2'b00;
        @(posedge clk); #1;
        check("bp2_drained", {31'd0, o_valid2}, 32'd0);

        // Three channels: wrap from rr_ptr=2 with only channel 1 valid.
        update_data3();
        o_ready3 = 1'b1;
        i_valid3 = 3'b010;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("wrap3_grant1", {29'd0, i_ready3}, 32'd2);
            q3.push_back({8'd1, word3(1, seq3[1])});
            @(posedge clk); #1;
            seq3[1]++;
            update_data3();
        end
        i_valid3 = 3'b111;
        #1;
        check("wrap3_ptr_kept", {29'd0, i_ready3}, 32'd4);
        q3.push_back({8'd2, word3(2, seq3[2])});
        @(posedge clk); #1;
        seq3[2]++;
        update_data3();

        // All valid with random consumer stalls: grants must rotate 0,1,2,...
        n = 0;
        for (int c = 0; c < 40; c++) begin
            o_ready3 = 1'($urandom_range(0, 1));
            #1;
            acc = i_valid3 & i_ready3;
            k = n % 3;
            if (|acc) begin
                check("rand3_grant", {29'd0, acc}, 32'(1 << k));
                q3.push_back({8'(k), word3(k, seq3[k])});
                n++;
            end
            @(posedge clk); #1;
            if (|acc) begin
                seq3[k]++;
                update_data3();
            end
        end
        i_valid3 = 3'b000;
        o_ready3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("q3_empty", 32'(q3.size()), 32'd0);
        check("q2_empty", 32'(q2.size()), 32'd0);
        check("rand3_progress", 32'(n >= 10), 32'd1);

        // Asynchronous reset while a word is held.
        i_valid2 = 2'b01;
        o_ready2 = 1'b0;
        @(posedge clk); #1;
        check("rst2_held", {31'd0, o_valid2}, 32'd1);
        #2;
        i_valid2 = 2'b11;
        o_ready2 = 1'b1;
        reset_n  = 1'b0;
        #1;
        check("rst2_o_valid", {31'd0, o_valid2}, 32'd0);
        check("rst2_o_data", {8'd0, o_data2}, 32'd0);
        check("rst2_i_ready", {30'd0, i_ready2}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        check("rst2_ptr_zero", {30'd0, i_ready2}, 32'd1);
        i_valid2 = 2'b00;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
